// File: rtl/conv_layer_ctrl.sv
// rtl/conv_layer_ctrl.sv - convolution layer tap walker with latency-aligned read, clear and write strobes
module conv_layer_ctrl #(
    parameter int K        = 5,
    parameter int IN_W     = 14,
    parameter int IN_H     = 14,
    parameter int STRIDE   = 1,
    parameter int OUT_CH   = 1,
    parameter int ADDR_LAT = 3,
    parameter int CLR_LAT  = 6,
    parameter int WR_LAT   = 13,
    localparam int OUT_W   = (IN_W - K) / STRIDE + 1,
    localparam int OUT_H   = (IN_H - K) / STRIDE + 1,
    localparam int FA_W    = (IN_W * IN_H > 1) ? $clog2(IN_W * IN_H) : 1,
    localparam int WA_W    = (OUT_CH * K * K > 1) ? $clog2(OUT_CH * K * K) : 1,
    localparam int OA_W    = (OUT_CH * OUT_W * OUT_H > 1) ? $clog2(OUT_CH * OUT_W * OUT_H) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [FA_W-1:0] f_raddr,
    output logic [WA_W-1:0] w_raddr,
    output logic            rd_en,
    output logic            conv_clr,
    output logic [OA_W-1:0] o_waddr,
    output logic            o_wr_en
);
    localparam int KC_W = (K > 1) ? $clog2(K) : 1;
    localparam int OX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int OY_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int OC_W = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          r_state;
    logic [KC_W-1:0] r_kc, r_kr;
    logic [OX_W-1:0] r_ox;
    logic [OY_W-1:0] r_oy;
    logic [OC_W-1:0] r_och;

    logic [ADDR_LAT-1:0] r_rd_v;
    logic [CLR_LAT-1:0]  r_clr_v;
    logic [WR_LAT-1:0]   r_wr_v;
    logic [FA_W-1:0]     r_fa_pipe [ADDR_LAT];
    logic [WA_W-1:0]     r_wa_pipe [ADDR_LAT];
    logic [OA_W-1:0]     r_oa_pipe [WR_LAT];

    logic w_issue, w_kc_last, w_kr_last, w_ox_last, w_oy_last, w_och_last, w_final;
    logic w_pipe_idle;
    logic [ADDR_LAT-1:0] w_rd_nxt;
    logic [CLR_LAT-1:0]  w_clr_nxt;
    logic [WR_LAT-1:0]   w_wr_nxt;
    logic [FA_W-1:0]     w_fa;
    logic [WA_W-1:0]     w_wa;
    logic [OA_W-1:0]     w_oa;

    assign w_issue    = (r_state == S_RUN) && !stall && !abort;
    assign w_kc_last  = (r_kc == KC_W'(K - 1));
    assign w_kr_last  = (r_kr == KC_W'(K - 1));
    assign w_ox_last  = (r_ox == OX_W'(OUT_W - 1));
    assign w_oy_last  = (r_oy == OY_W'(OUT_H - 1));
    assign w_och_last = (r_och == OC_W'(OUT_CH - 1));
    assign w_final    = w_kc_last && w_kr_last && w_ox_last && w_oy_last && w_och_last;

    assign w_fa = FA_W'((32'(r_oy) * STRIDE + 32'(r_kr)) * IN_W + 32'(r_ox) * STRIDE + 32'(r_kc));
    assign w_wa = WA_W'(32'(r_och) * K * K + 32'(r_kr) * K + 32'(r_kc));
    assign w_oa = OA_W'(32'(r_och) * OUT_W * OUT_H + 32'(r_oy) * OUT_W + 32'(r_ox));

    // Valid shift lines: the size cast drops the bit leaving the far end.
    assign w_rd_nxt  = ADDR_LAT'({r_rd_v, w_issue});
    assign w_clr_nxt = CLR_LAT'({r_clr_v, w_issue && r_kc == '0 && r_kr == '0});
    assign w_wr_nxt  = WR_LAT'({r_wr_v, w_issue && w_kc_last && w_kr_last});

    // Looking at next-cycle contents lets done land one cycle after the final strobe.
    assign w_pipe_idle = (w_rd_nxt == '0) && (w_clr_nxt == '0) && (w_wr_nxt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_kc    <= '0;
            r_kr    <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_och   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                r_kc    <= '0;
                r_kr    <= '0;
                r_ox    <= '0;
                r_oy    <= '0;
                r_och   <= '0;
                busy    <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        busy <= start;
                        if (start) r_state <= S_RUN;
                    end
                    S_RUN: begin
                        busy <= 1'b1;
                        if (w_issue) begin
                            r_kc <= w_kc_last ? '0 : r_kc + 1'b1;
                            if (w_kc_last) begin
                                r_kr <= w_kr_last ? '0 : r_kr + 1'b1;
                                if (w_kr_last) begin
                                    r_ox <= w_ox_last ? '0 : r_ox + 1'b1;
                                    if (w_ox_last) begin
                                        r_oy <= w_oy_last ? '0 : r_oy + 1'b1;
                                        if (w_oy_last) r_och <= w_och_last ? '0 : r_och + 1'b1;
                                    end
                                end
                            end
                            if (w_final) r_state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (w_pipe_idle) begin
                            r_state <= S_IDLE;
                            done    <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_v  <= '0;
            r_clr_v <= '0;
            r_wr_v  <= '0;
            for (int i = 0; i < ADDR_LAT; i++) begin
                r_fa_pipe[i] <= '0;
                r_wa_pipe[i] <= '0;
            end
            for (int i = 0; i < WR_LAT; i++) r_oa_pipe[i] <= '0;
        end else begin
            if (abort) begin
                r_rd_v  <= '0;
                r_clr_v <= '0;
                r_wr_v  <= '0;
            end else begin
                r_rd_v  <= w_rd_nxt;
                r_clr_v <= w_clr_nxt;
                r_wr_v  <= w_wr_nxt;
            end
            r_fa_pipe[0] <= w_fa;
            r_wa_pipe[0] <= w_wa;
            for (int i = 1; i < ADDR_LAT; i++) begin
                r_fa_pipe[i] <= r_fa_pipe[i-1];
                r_wa_pipe[i] <= r_wa_pipe[i-1];
            end
            r_oa_pipe[0] <= w_oa;
            for (int i = 1; i < WR_LAT; i++) r_oa_pipe[i] <= r_oa_pipe[i-1];
        end
    end

    assign rd_en    = r_rd_v[ADDR_LAT-1];
    assign f_raddr  = r_fa_pipe[ADDR_LAT-1];
    assign w_raddr  = r_wa_pipe[ADDR_LAT-1];
    assign conv_clr = r_clr_v[CLR_LAT-1];
    assign o_wr_en  = r_wr_v[WR_LAT-1];
    assign o_waddr  = r_oa_pipe[WR_LAT-1];
endmodule

// File: doc/conv_layer_ctrl.md
# conv_layer_ctrl

Parametrised control generator for one convolution layer. It walks output channels, output rows, output columns and kernel taps, and emits a weight read address and an input-feature read address per tap, plus per-pixel accumulator clear and output-feature write strobes. Every stream is delayed to line up with a fixed-latency MAC datapath. It supersedes the fixed-geometry per-layer controllers, and adds stride, output-channel looping, stall, abort and a busy/done handshake.

## Interface
- K, 5: kernel width and height (square kernel), ≥1
- IN_W, 14: input feature width
- IN_H, 14: input feature height
- STRIDE, 1: convolution stride, ≥1
- OUT_CH, 1: number of output channels walked sequentially
- ADDR_LAT, 3: cycles from tap issue to read-address outputs
- CLR_LAT, 6: cycles from first-tap issue to conv_clr
- WR_LAT, 13: cycles from last-tap issue to o_wr_en/o_waddr
- Derived: OUT_W=(IN_W-K)/STRIDE+1, OUT_H=(IN_H-K)/STRIDE+1; FA_W=clog2(IN_W*IN_H), WA_W=clog2(OUT_CH*K*K), OA_W=clog2(OUT_CH*OUT_W*OUT_H), each minimum 1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request; accepted only in IDLE
- stall  in  1  holds tap issue while high
- abort  in  1  synchronous cancel
- busy  out  1  high from the cycle after accept until done, or until abort
- done  out  1  one-cycle pulse on completion
- f_raddr  out  FA_W  input feature read address
- w_raddr  out  WA_W  weight read address
- rd_en  out  1  f_raddr/w_raddr valid
- conv_clr  out  1  clear accumulator (first tap of a pixel)
- o_waddr  out  OA_W  output feature write address
- o_wr_en  out  1  output write strobe

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN on start.
  - RUN→DRAIN on the issue of the final tap (och=OUT_CH-1, oy=OUT_H-1, ox=OUT_W-1, kr=kc=K-1).
  - DRAIN→IDLE when the delay pipeline is empty. done pulses in that same cycle.
- Counters nest innermost→outermost: kc (0..K-1), kr, ox (0..OUT_W-1), oy, och. Each wraps to 0 and carries outward.
- A tap issues in every RUN cycle with stall=0. With stall=1, counters hold and a bubble (valid=0) enters the pipeline.
- Tap address arithmetic (full precision, no truncation within range):
  - f_raddr = (oy*STRIDE+kr)*IN_W + ox*STRIDE + kc
  - w_raddr = och*K*K + kr*K + kc
- Per-pixel address: o_waddr = och*OUT_W*OUT_H + oy*OUT_W + ox.
- Every issued tap carries a valid bit through the delay lines:
  - rd_en = valid delayed ADDR_LAT.
  - conv_clr = (valid && kc==0 && kr==0) delayed CLR_LAT.
  - o_wr_en = (valid && kc==K-1 && kr==K-1) delayed WR_LAT, with o_waddr aligned to it.
- Bubbles never produce rd_en, conv_clr or o_wr_en.
- start in RUN or DRAIN is ignored.
- abort (any state): next state IDLE, counters cleared, all pipeline valid bits cleared next cycle, no done pulse. Address outputs may hold stale values.
- abort and start in the same cycle: abort wins.
- K=1: conv_clr and o_wr_en both derive from every tap.

## Timing
- Reset: state IDLE, all counters 0, all outputs 0, all pipeline stages 0.
- Accept at edge t: busy=1 and the first tap issues in cycle t+1.
- Tap issued in cycle c:
  - f_raddr/w_raddr/rd_en valid in c+ADDR_LAT.
  - conv_clr in c+CLR_LAT.
  - o_wr_en in c+WR_LAT.
- Unstalled run: K*K*OUT_W*OUT_H*OUT_CH issue cycles. done is asserted WR_LAT+1 cycles after the last issue cycle, i.e. one cycle after the final o_wr_en.
- busy falls in the cycle after done.
- Stall inserts exactly one cycle of latency per stalled cycle. Spacing of outputs follows the issue pattern.
- A start arriving in the cycle after done is accepted.

## Test plan
- Defaults, single start, no stall:
  - 2500 rd_en, 100 conv_clr and 100 o_wr_en pulses.
  - o_waddr 0..99 in order.
  - First f_raddr sequence 0,1,2,3,4,14,15,…; w_raddr 0..24.
  - done one cycle after the wr_en with o_waddr=99.
- STRIDE=2, IN_W=IN_H=8, K=2, OUT_CH=2:
  - OUT_W=4; 32 writes, o_waddr 0..31.
  - Pixel (ox=1, oy=1) taps f_raddr 18,19,26,27.
  - Channel 1 w_raddr 4..7.
- Random stall (≈30%) on defaults:
  - Identical address/strobe sequences to the unstalled run.
  - No strobe during bubbles.
  - Total cycles = unstalled count + stalled cycles.
- abort mid-RUN (after 600 issues):
  - No o_wr_en after the drain window; done never pulses; busy=0 next cycle.
  - A following start produces a full, correct run from o_waddr 0.
- start pulsed while busy: no effect on sequence or counts. start the cycle after done: second run begins.
- rst_n asserted mid-run: all outputs 0 immediately; after release, IDLE and no strobes until start.
